// File: rtl/dec_branch_counters.sv
// dec_branch_counters
//   Commit-side executor for the custom branch-counter instructions. Keeps a
//   committed-branch count (bcount) and a taken-branch count (btcount), each
//   with a sticky overflow flag, and returns counter reads to the i0/i1
//   writeback path one cycle after the read commits.
//
// Ports
//   clk, rst                 core clock, asynchronous active-high reset
//   i0_* / i1_*              per-slot commit info and decoded counter ops;
//                            i1 is younger than i0 and sees i0's effect
//   running                  counting enabled (FSM in RUNNING)
//   bcount, btcount          live counter values (registered)
//   bcount_ovf, btcount_ovf  sticky wrap/saturate flags
//   i0_rd_valid/addr/data    registered read result for slot i0
//   i1_rd_valid/addr/data    registered read result for slot i1
//
// State | meaning
//   STOPPED | branches are not counted
//   RUNNING | committed branches increment the counters

module dec_branch_counters #(
  parameter int CNT_WIDTH = 32,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i0_valid,
  input  logic                 i0_br,
  input  logic                 i0_br_taken,
  input  logic                 i0_bcount_reset,
  input  logic                 i0_btcount_reset,
  input  logic                 i0_start,
  input  logic                 i0_stop,
  input  logic                 i0_bcount_read,
  input  logic                 i0_btcount_read,
  input  logic [4:0]           i0_rd,
  input  logic                 i1_valid,
  input  logic                 i1_br,
  input  logic                 i1_br_taken,
  input  logic                 i1_bcount_reset,
  input  logic                 i1_btcount_reset,
  input  logic                 i1_start,
  input  logic                 i1_stop,
  input  logic                 i1_bcount_read,
  input  logic                 i1_btcount_read,
  input  logic [4:0]           i1_rd,
  output logic                 running,
  output logic [CNT_WIDTH-1:0] bcount,
  output logic [CNT_WIDTH-1:0] btcount,
  output logic                 bcount_ovf,
  output logic                 btcount_ovf,
  output logic                 i0_rd_valid,
  output logic [4:0]           i0_rd_addr,
  output logic [CNT_WIDTH-1:0] i0_rd_data,
  output logic                 i1_rd_valid,
  output logic [4:0]           i1_rd_addr,
  output logic [CNT_WIDTH-1:0] i1_rd_data
);

  localparam int W = CNT_WIDTH;

  typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

  typedef struct packed {
    state_t         st;
    logic [W-1:0]   bc;
    logic [W-1:0]   btc;
    logic           bo;
    logic           bto;
  } ctx_t;

  state_t       state, state_nxt;
  ctx_t         cur, mid, fin;
  logic         i0_rd_valid_nxt, i1_rd_valid_nxt;
  logic [W-1:0] i0_rd_data_nxt, i1_rd_data_nxt;

  // Returns {carry, value}; carry marks a crossing of all-ones.
  function automatic logic [W:0] bump(logic [W-1:0] v);
    logic [W:0] sum;
    sum = {1'b0, v} + {{W{1'b0}}, 1'b1};
    if (SATURATE && sum[W]) sum[W-1:0] = {W{1'b1}};
    return sum;
  endfunction

  // One slot acting on a context; chained twice so i1 sees i0's result.
  function automatic ctx_t step(ctx_t c, logic valid, logic br, logic taken,
                                logic brst, logic btrst, logic start, logic stop);
    ctx_t       n;
    logic [W:0] s;
    n = c;
    s = '0;
    if (valid) begin
      if (brst) begin
        n.bc = '0;
        n.bo = 1'b0;
      end
      if (btrst) begin
        n.btc = '0;
        n.bto = 1'b0;
      end
      if (br && c.st == RUNNING) begin
        s    = bump(c.bc);
        n.bc = s[W-1:0];
        n.bo = c.bo | s[W];
        if (taken) begin
          s     = bump(c.btc);
          n.btc = s[W-1:0];
          n.bto = c.bto | s[W];
        end
      end
      if (stop)       n.st = STOPPED;
      else if (start) n.st = RUNNING;
    end
    return n;
  endfunction

  always_comb begin
    cur.st  = state;
    cur.bc  = bcount;
    cur.btc = btcount;
    cur.bo  = bcount_ovf;
    cur.bto = btcount_ovf;
    mid = step(cur, i0_valid, i0_br, i0_br_taken, i0_bcount_reset,
               i0_btcount_reset, i0_start, i0_stop);
    fin = step(mid, i1_valid, i1_br, i1_br_taken, i1_bcount_reset,
               i1_btcount_reset, i1_start, i1_stop);
    state_nxt = fin.st;
    i0_rd_valid_nxt = i0_valid & (i0_bcount_read | i0_btcount_read);
    i0_rd_data_nxt  = i0_bcount_read ? cur.bc : cur.btc;
    i1_rd_valid_nxt = i1_valid & (i1_bcount_read | i1_btcount_read);
    i1_rd_data_nxt  = i1_bcount_read ? mid.bc : mid.btc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= STOPPED;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcount      <= '0;
      btcount     <= '0;
      bcount_ovf  <= 1'b0;
      btcount_ovf <= 1'b0;
      i0_rd_valid <= 1'b0;
      i0_rd_addr  <= '0;
      i0_rd_data  <= '0;
      i1_rd_valid <= 1'b0;
      i1_rd_addr  <= '0;
      i1_rd_data  <= '0;
    end else begin
      bcount      <= fin.bc;
      btcount     <= fin.btc;
      bcount_ovf  <= fin.bo;
      btcount_ovf <= fin.bto;
      i0_rd_valid <= i0_rd_valid_nxt;
      i1_rd_valid <= i1_rd_valid_nxt;
      // Address and data hold between reads.
      if (i0_rd_valid_nxt) begin
        i0_rd_addr <= i0_rd;
        i0_rd_data <= i0_rd_data_nxt;
      end
      if (i1_rd_valid_nxt) begin
        i1_rd_addr <= i1_rd;
        i1_rd_data <= i1_rd_data_nxt;
      end
    end
  end

  assign running = (state == RUNNING);

  // start and stop together are legal (stop wins), so they count as one op.
  a_i0_one_op: assert property (@(posedge clk) disable iff (rst)
    i0_valid |-> $onehot0({i0_br, i0_bcount_reset, i0_btcount_reset,
                           i0_start | i0_stop, i0_bcount_read, i0_btcount_read}));
  a_i1_one_op: assert property (@(posedge clk) disable iff (rst)
    i1_valid |-> $onehot0({i1_br, i1_bcount_reset, i1_btcount_reset,
                           i1_start | i1_stop, i1_bcount_read, i1_btcount_read}));

endmodule
